// File: rtl/seq_shift_add_multiplier.sv
// 16x16 unsigned shift-add multiplier driving an external 16-bit adder, one partial product per clock.
// Latency: 17 cycles from the start edge to done; MUL_EARLY_TERM_EN finishes once the remaining multiplier bits are all zero.
// Backpressure: busy stalls the issuer, start is ignored while busy and accepted again in the done cycle.
module seq_shift_add_multiplier #(
  parameter int WIDTH      = 16,
  parameter int ITER_CNT_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic [WIDTH-1:0]     add_in1,
  output logic [WIDTH-1:0]     add_in2,
  output logic                 add_cin,
  input  logic [WIDTH-1:0]     add_sum,
  input  logic                 add_carry
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [ITER_CNT_W-1:0] LAST_ITER = ITER_CNT_W'(WIDTH - 1);

  state_t                state_q, state_d;
  logic [WIDTH-1:0]      acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0]      acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0]      mcand_q, mcand_d;
  logic [ITER_CNT_W-1:0] count_q, count_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

`ifdef MUL_EARLY_TERM_EN
  logic [WIDTH-1:0]      rem_q, rem_d;
  logic [ITER_CNT_W:0]   shift_amt;
  logic [2*WIDTH-1:0]    acc_aligned;
`endif

  // Adder inputs are held at zero outside BUSY so the shared adder stays quiet.
  always_comb begin
    add_in1 = '0;
    add_in2 = '0;
    if (state_q == BUSY) begin
      add_in1 = acc_hi_q;
      add_in2 = acc_lo_q[0] ? mcand_q : '0;
    end
  end

  assign add_cin = 1'b0;

  always_comb begin
    state_d  = state_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    mcand_d  = mcand_q;
    count_d  = count_q;
`ifdef MUL_EARLY_TERM_EN
    rem_d       = rem_q;
    shift_amt   = (ITER_CNT_W + 1)'(WIDTH) - {1'b0, count_q};
    acc_aligned = {acc_hi_q, acc_lo_q} >> shift_amt;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          mcand_d  = multiplicand;
          acc_hi_d = '0;
          acc_lo_d = multiplier;
          count_d  = '0;
          state_d  = BUSY;
`ifdef MUL_EARLY_TERM_EN
          rem_d    = multiplier;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        // Carry-out lands in bit 31 of the right-shifted accumulator.
        {acc_hi_d, acc_lo_d} = {add_carry, add_sum, acc_lo_q[WIDTH-1:1]};
        count_d = count_q + 1'b1;
        if (count_q == LAST_ITER) state_d = DONE;
`ifdef MUL_EARLY_TERM_EN
        rem_d = rem_q >> 1;
        if (rem_q == '0) begin
          {acc_hi_d, acc_lo_d} = acc_aligned;
          count_d = count_q;
          rem_d   = rem_q;
          state_d = DONE;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == BUSY);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      mcand_q  <= '0;
      count_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef MUL_EARLY_TERM_EN
      rem_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      mcand_q  <= mcand_d;
      count_q  <= count_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef MUL_EARLY_TERM_EN
      rem_q    <= rem_d;
`endif
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = {acc_hi_q, acc_lo_q};

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Bench for seq_shift_add_multiplier: behavioural adder, directed scenarios plus random operands
// checked against plain a*b and the expected latency (with or without MUL_EARLY_TERM_EN).
module tb_seq_shift_add_multiplier;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] mcand_i;
  logic [15:0] mplier_i;
  logic        busy;
  logic        done;
  logic [31:0] product;
  logic [15:0] add_in1;
  logic [15:0] add_in2;
  logic        add_cin;
  logic [15:0] add_sum;
  logic        add_carry;
  logic [16:0] add_res;

  int checks   = 0;
  int failures = 0;

  seq_shift_add_multiplier #(.WIDTH(16), .ITER_CNT_W(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .multiplicand (mcand_i),
    .multiplier   (mplier_i),
    .busy         (busy),
    .done         (done),
    .product      (product),
    .add_in1      (add_in1),
    .add_in2      (add_in2),
    .add_cin      (add_cin),
    .add_sum      (add_sum),
    .add_carry    (add_carry)
  );

  // The external carry-lookahead adder, modelled as a plain 17-bit sum.
  assign add_res   = {1'b0, add_in1} + {1'b0, add_in2} + {16'b0, add_cin};
  assign add_sum   = add_res[15:0];
  assign add_carry = add_res[16];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int exp_lat(input logic [15:0] b);
    int k;
    k = -1;
    for (int i = 0; i < 16; i++) if (b[i]) k = i;
`ifdef MUL_EARLY_TERM_EN
    return (k + 3 < 17) ? k + 3 : 17;
`else
    return 17;
`endif
  endfunction

  function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
    logic [63:0] p;
    p = 64'(a) * 64'(b);
    return p[31:0];
  endfunction

  // Leaves the caller #1 after the accepting edge; start is left asserted.
  task automatic issue(input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    start    = 1'b1;
    mcand_i  = a;
    mplier_i = b;
    @(posedge clk);
    #1;
  endtask

  // Called #1 after the accepting edge; returns #1 after the edge that raised done.
  task automatic wait_done(input string tag, input logic [31:0] exp_p, input int exp_l, input int poke);
    int n;
    int bc;
    n  = 0;
    bc = 0;
    while (!done && n < 60) begin
      if (busy) bc++;
      if (poke >= 0 && n == poke) begin
        start    = 1'b1;
        mcand_i  = 16'h0002;
        mplier_i = 16'h0002;
      end else if (poke >= 0 && n == poke + 1) begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_lat"}, 64'(n + 1), 64'(exp_l));
    check({tag, "_busy_cycles"}, 64'(bc), 64'(exp_l - 1));
    check({tag, "_prod"}, 64'(product), 64'(exp_p));
  endtask

  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b);
    logic [31:0] p;
    p = ref_mul(a, b);
    issue(a, b);
    start = 1'b0;
    wait_done(tag, p, exp_lat(b), -1);
    @(posedge clk);
    #1;
    check({tag, "_pulse"}, 64'(done), 64'd0);
    check({tag, "_hold"}, 64'(product), 64'(p));
  endtask

  initial begin
    logic [15:0] a;
    logic [15:0] b;
    int          dones;

    rst_n    = 1'b0;
    start    = 1'b0;
    mcand_i  = '0;
    mplier_i = '0;
    #2;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_prod", 64'(product), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op("t1_3x5", 16'd3, 16'd5);
    run_op("t2_ffff", 16'hFFFF, 16'hFFFF);

    // Second request while busy must be ignored.
    issue(16'h1234, 16'h0010);
    start = 1'b0;
    wait_done("t3_poke", 32'h0001_2340, exp_lat(16'h0010), 3);
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (done) dones++;
    end
    check("t3_no_second_done", 64'(dones), 64'd0);
    check("t3_prod_held", 64'(product), 64'h0001_2340);

    // start held high across BUSY and DONE: back-to-back issue.
    a = 16'(($urandom % 16'hFFFF) + 1);
    b = 16'(($urandom % 16'hFFFF) + 1);
    issue(a, b);
    mcand_i  = 16'h0007;
    mplier_i = 16'h0009;
    wait_done("t4_first", ref_mul(a, b), exp_lat(b), -1);
    @(posedge clk);
    #1;
    start = 1'b0;
    check("t4_rearm_busy", 64'(busy), 64'd1);
    wait_done("t4_second", 32'd63, exp_lat(16'h0009), -1);

    // Asynchronous reset in BUSY cycle 8.
    repeat (3) @(posedge clk);
    issue(16'h00FF, 16'h00FF);
    start = 1'b0;
    repeat (7) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("t5_rst_busy", 64'(busy), 64'd0);
    check("t5_rst_done", 64'(done), 64'd0);
    check("t5_rst_prod", 64'(product), 64'd0);
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (done) dones++;
    end
    check("t5_no_done", 64'(dones), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("t5_fresh", 16'h00FF, 16'h00FF);

    run_op("t6_zero", 16'hABCD, 16'h0000);
    run_op("edge_1x1", 16'h0001, 16'h0001);
    run_op("edge_msb", 16'hFFFF, 16'h8000);

    for (int i = 0; i < 24; i++) begin
      a = 16'($urandom);
      case (i % 3)
        0:       b = 16'($urandom);
        1:       b = 16'($urandom) & 16'((32'd1 << $urandom_range(0, 16)) - 32'd1);
        default: b = 16'(32'd1 << $urandom_range(0, 15));
      endcase
      run_op($sformatf("rnd%0d", i), a, b);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
